ntt_sequencer: RTL and testbench
================================

NTT_SEQUENCER -- requirements
Module: ntt_sequencer

Interface
REQ-001 Parameter BF_LATENCY, default 4: butterfly datapath latency in cycles, from read address to write address; legal range 1..8.
REQ-002 Parameter AW, default 17: coefficient address width.
REQ-003 Port clk, input, 1: single clock; all logic on rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 Port ntt_start, input, 1: start request, sampled in IDLE only.
REQ-006 Port param_n, input, 17: transform length N, captured at accepted start.
REQ-007 Ports raddr1_o and raddr2_o, output, AW each: butterfly read addresses (top/bottom).
REQ-008 Ports waddr1_o and waddr2_o, output, AW each: butterfly write-back addresses.
REQ-009 Port we_o, output, 1: write enable qualifying waddr1_o/waddr2_o.
REQ-010 Port rvalid_o, output, 1: read addresses valid this cycle.
REQ-011 Port twiddle_idx_o, output, 16: twiddle (zeta) table index, aligned with read addresses.
REQ-012 Port busy_o, output, 1: high in every state except IDLE.
REQ-013 Port done_o, output, 1: one-cycle completion pulse.
REQ-014 Port err_o, output, 1: one-cycle pulse, coincident with done_o, for an illegal N.

Function
REQ-015 The FSM SHALL have four states: IDLE, RUN, DRAIN, DONE.
REQ-016 IDLE transitions:
- ntt_start=1 and N legal (power of two, 4..65536): latch N, set stage s=0, butterfly counter b=0, go to RUN.
- ntt_start=1 and N illegal: go to DONE with err flag set; no reads or writes are issued.
REQ-017 RUN SHALL issue one butterfly per cycle with rvalid_o=1, for b = 0..N/2-1, using half = N>>(s+1):
- raddr1_o = (b/half)*2*half + (b mod half)
- raddr2_o = raddr1_o + half
- twiddle_idx_o = 2^s + b/half
REQ-018 After b = N/2-1, RUN SHALL go to DRAIN, and b SHALL reset to 0.
REQ-019 DRAIN SHALL last exactly BF_LATENCY cycles with rvalid_o=0.
REQ-020 DRAIN exit:
- s < log2(N)-1: increment s and return to RUN.
- otherwise: go to DONE.
REQ-021 DONE SHALL last one cycle, assert done_o (and err_o if flagged), then return to IDLE.
REQ-022 Write-back timing: waddr1_o/waddr2_o/we_o SHALL equal raddr1_o/raddr2_o/rvalid_o delayed by exactly BF_LATENCY cycles.
REQ-023 The last write of a stage SHALL occur no later than the cycle before the first read of the next stage (no RAW hazard).
REQ-024 ntt_start while busy_o=1 SHALL be ignored; param_n changes while busy SHALL have no effect.
REQ-025 ntt_start held high SHALL restart a new transform in the cycle after DONE returns to IDLE.
REQ-026 Outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-027 When rvalid_o=0, the read addresses and twiddle_idx_o SHALL be 0; when we_o=0, the write addresses SHALL be 0.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force:
- state IDLE and all counters to 0;
- the delay line cleared;
- all outputs to 0 on the following cycle, including mid-transform (no pending we_o survives).

Structure
REQ-029 Package ntt_pkg SHALL hold:
- the FSM state enum;
- constants N_MIN=4, N_MAX=65536, BF_LATENCY_MAX=8.
REQ-030 The write delay line SHALL be sub-module ntt_addr_delay, parameterised by depth and width, with synchronous active-low clear.

Verification
REQ-031 N=8, BF_LATENCY=4, start at cycle 0:
- stage 0 reads (0,4),(1,5),(2,6),(3,7), twiddle 1,1,1,1;
- stage 1 reads (0,2),(1,3),(4,6),(5,7), twiddle 2,2,3,3;
- stage 2 reads (0,1),(2,3),(4,5),(6,7), twiddle 4,5,6,7;
- done_o at cycle 25.
REQ-032 In the same run, each we_o pair SHALL appear exactly 4 cycles after its read, and 12 writes total SHALL occur.
REQ-033 N=256: exactly 8 stages of 128 reads; done_o at cycle 8*(128+4)+1 = 1057; busy_o high from cycle 1 through cycle 1057.
REQ-034 N=96 (not a power of two), then N=2 (below N_MIN):
- each gives err_o=done_o=1 one cycle after start;
- we_o and rvalid_o remain 0 throughout.
REQ-035 N=16: rst_n=0 during stage 2 of a run:
- all outputs are 0 on the next cycle;
- a following start with N=8 reproduces the REQ-031 sequence exactly.
REQ-036 ntt_start pulsed again mid-run with param_n=1024 SHALL have no effect on the N=8 schedule or the done_o timing.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT address sequencer.
// Holds the FSM state encoding, transform-length limits and small helpers.
package ntt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ntt_state_e;

    localparam int unsigned N_MIN          = 4;
    localparam int unsigned N_MAX          = 65536;
    localparam int unsigned BF_LATENCY_MAX = 8;
    localparam int unsigned N_W            = 17;
    localparam int unsigned TW_W           = 16;

    // A legal length is a power of two inside [N_MIN, N_MAX].
    function automatic logic ntt_n_legal(input logic [16:0] n);
        return (n >= 17'(N_MIN)) && (n <= 17'(N_MAX)) && ((n & (n - 17'd1)) == 17'd0);
    endfunction

    function automatic logic [4:0] ntt_log2(input logic [16:0] n);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < int'(N_W); i++) begin
            if (n[i]) begin
                r = 5'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ntt_addr_delay.sv
// Fixed-depth shift register that turns read-side address/valid words into
// write-side words; synchronous active-low clear empties every slot.
module ntt_addr_delay
    import ntt_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 35
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] pipe_q [DEPTH];
    logic [WIDTH-1:0] pipe_d [DEPTH];

    always_comb begin
        pipe_d[0] = d_i;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/ntt_sequencer.sv
// Address/twiddle sequencer for an in-place radix-2 NTT: one butterfly per cycle,
// a drain gap of BF_LATENCY cycles between stages, write-back via a delay line.
module ntt_sequencer
    import ntt_pkg::*;
#(
    parameter int BF_LATENCY = 4,
    parameter int AW         = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ntt_start,
    input  logic [16:0]   param_n,
    output logic [AW-1:0] raddr1_o,
    output logic [AW-1:0] raddr2_o,
    output logic [AW-1:0] waddr1_o,
    output logic [AW-1:0] waddr2_o,
    output logic          we_o,
    output logic          rvalid_o,
    output logic [15:0]   twiddle_idx_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    localparam logic [3:0] DRAIN_LAST = 4'(BF_LATENCY - 1);
    localparam int         DW         = 2 * AW + 1;

    ntt_state_e  state_q, state_d;
    logic [4:0]  logn_q, logn_d;
    logic [3:0]  s_q, s_d;
    logic [15:0] b_q, b_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [15:0] last_b;

    logic [AW-1:0] raddr1_q, raddr1_d;
    logic [AW-1:0] raddr2_q, raddr2_d;
    logic [15:0]   tw_q, tw_d;
    logic          rvalid_q, rvalid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_o_q, err_o_d;

    logic [4:0]  half_shift;
    logic [16:0] mask;
    logic [16:0] b_ext;
    logic [16:0] addr1_full;
    logic [16:0] addr2_full;

    logic [DW-1:0] dly_in;
    logic [DW-1:0] dly_out;

    assign last_b = 16'((17'd1 << (logn_q - 5'd1)) - 17'd1);

    always_comb begin
        state_d = state_q;
        logn_d  = logn_q;
        s_d     = s_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (ntt_start) begin
                    s_d   = '0;
                    b_d   = '0;
                    cnt_d = '0;
                    if (ntt_n_legal(param_n)) begin
                        state_d = ST_RUN;
                        logn_d  = ntt_log2(param_n);
                        err_d   = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (b_q == last_b) begin
                    state_d = ST_DRAIN;
                    b_d     = '0;
                    cnt_d   = '0;
                end else begin
                    b_d = b_q + 16'd1;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d = '0;
                    if ({1'b0, s_q} < (logn_q - 5'd1)) begin
                        s_d     = s_q + 4'd1;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are computed from the next-state counters so the registered
    // addresses line up with the cycle the FSM actually spends in RUN.
    always_comb begin
        half_shift = logn_d - 5'd1 - {1'b0, s_d};
        mask       = (17'd1 << half_shift) - 17'd1;
        b_ext      = {1'b0, b_d};
        addr1_full = ((b_ext & ~mask) << 1) | (b_ext & mask);
        addr2_full = addr1_full + mask + 17'd1;

        rvalid_d = (state_d == ST_RUN);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
        err_o_d  = (state_d == ST_DONE) && err_d;
        raddr1_d = '0;
        raddr2_d = '0;
        tw_d     = '0;
        if (rvalid_d) begin
            raddr1_d = AW'(addr1_full);
            raddr2_d = AW'(addr2_full);
            tw_d     = (16'd1 << s_d) + 16'(b_ext >> half_shift);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            logn_q   <= '0;
            s_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            raddr1_q <= '0;
            raddr2_q <= '0;
            tw_q     <= '0;
            rvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_o_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            logn_q   <= logn_d;
            s_q      <= s_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            raddr1_q <= raddr1_d;
            raddr2_q <= raddr2_d;
            tw_q     <= tw_d;
            rvalid_q <= rvalid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_o_q  <= err_o_d;
        end
    end

    // Read addresses are already zero when invalid, so the delayed words
    // keep write addresses at zero whenever we_o is low.
    assign dly_in = {rvalid_q, raddr1_q, raddr2_q};

    ntt_addr_delay #(
        .DEPTH (BF_LATENCY),
        .WIDTH (DW)
    ) u_wdelay (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (dly_in),
        .q_o   (dly_out)
    );

    assign we_o          = dly_out[DW-1];
    assign waddr1_o      = dly_out[2*AW-1:AW];
    assign waddr2_o      = dly_out[AW-1:0];
    assign raddr1_o      = raddr1_q;
    assign raddr2_o      = raddr2_q;
    assign twiddle_idx_o = tw_q;
    assign rvalid_o      = rvalid_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_o_q;

endmodule

// File: tb/tb_ntt_sequencer.sv
// Self-checking bench for ntt_sequencer: directed and randomized transforms
// compared cycle by cycle against an arithmetic schedule model.
module tb_ntt_sequencer;

    localparam int LAT = 4;

    typedef struct packed {
        logic        v;
        logic [16:0] a1;
        logic [16:0] a2;
        logic [15:0] tw;
    } rd_t;

    logic        clk;
    logic        rst_n;
    logic        ntt_start;
    logic [16:0] param_n;
    logic [16:0] raddr1_o, raddr2_o, waddr1_o, waddr2_o;
    logic        we_o, rvalid_o, busy_o, done_o, err_o;
    logic [15:0] twiddle_idx_o;
    logic [88:0] obs;

    int errors;
    int checks;
    logic [49:0] rd_log[$];

    int t_a1[12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
    int t_a2[12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
    int t_tw[12] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7};

    ntt_sequencer #(
        .BF_LATENCY (LAT),
        .AW         (17)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ntt_start     (ntt_start),
        .param_n       (param_n),
        .raddr1_o      (raddr1_o),
        .raddr2_o      (raddr2_o),
        .waddr1_o      (waddr1_o),
        .waddr2_o      (waddr2_o),
        .we_o          (we_o),
        .rvalid_o      (rvalid_o),
        .twiddle_idx_o (twiddle_idx_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    assign obs = {rvalid_o, raddr1_o, raddr2_o, twiddle_idx_o,
                  we_o, waddr1_o, waddr2_o, busy_o, done_o, err_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit n_legal(int n);
        return (n >= 4) && (n <= 65536) && ((n & (n - 1)) == 0);
    endfunction

    // Read issued r cycles after the start-sampling edge, from the stage/butterfly formulas.
    function automatic rd_t read_at(int n, int r);
        rd_t x;
        int  k, per, lg, s, b, half;
        x   = '0;
        lg  = $clog2(n);
        per = n / 2 + LAT;
        k   = r - 1;
        if (k >= 0) begin
            s = k / per;
            b = k % per;
            if (s < lg && b < n / 2) begin
                half = n >> (s + 1);
                x.v  = 1'b1;
                x.a1 = 17'((b / half) * 2 * half + b % half);
                x.a2 = 17'((b / half) * 2 * half + b % half + half);
                x.tw = 16'((1 << s) + b / half);
            end
        end
        return x;
    endfunction

    function automatic logic [88:0] exp_vec(int n, int r);
        rd_t  rd, wr;
        logic busy, done, err;
        int   last;
        rd = '0;
        wr = '0;
        if (!n_legal(n)) begin
            busy = (r == 1);
            done = (r == 1);
            err  = (r == 1);
        end else begin
            last = $clog2(n) * (n / 2 + LAT) + 1;
            rd   = read_at(n, r);
            wr   = read_at(n, r - LAT);
            busy = (r >= 1) && (r <= last);
            done = (r == last);
            err  = 1'b0;
        end
        return {rd.v, rd.a1, rd.a2, rd.tw, wr.v, wr.a1, wr.a2, busy, done, err};
    endfunction

    task automatic check_output(input string tag, input int idx,
                                input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s idx=%0d observed=%h expected=%h", tag, idx, observed, expected);
        end
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_output(tag, i, 128'(obs), 128'd0);
        end
    endtask

    // Caller enters in an IDLE cycle; start is sampled at the next edge (r=0 -> r=1).
    task automatic apply_stimulus(input string tag, input int n, input bit hold,
                                  input int pulse_r, input int abort_r);
        int last, reads, writes, busy_cnt, done_r, exp_reads;
        reads    = 0;
        writes   = 0;
        busy_cnt = 0;
        done_r   = -1;
        last     = n_legal(n) ? $clog2(n) * (n / 2 + LAT) + 1 : 1;
        exp_reads = n_legal(n) ? $clog2(n) * (n / 2) : 0;
        ntt_start = 1'b1;
        param_n   = 17'(n);
        for (int r = 1; r <= last; r++) begin
            @(posedge clk);
            #1;
            check_output(tag, r, 128'(obs), 128'(exp_vec(n, r)));
            if (rvalid_o) begin
                reads++;
                rd_log.push_back({raddr1_o, raddr2_o, twiddle_idx_o});
            end
            if (we_o) writes++;
            if (busy_o) busy_cnt++;
            if (done_o && done_r < 0) done_r = r;
            if (r == abort_r) begin
                rst_n     = 1'b0;
                ntt_start = 1'b0;
                @(posedge clk);
                #1;
                check_output({tag, "_after_reset"}, r + 1, 128'(obs), 128'd0);
                rst_n = 1'b1;
                return;
            end
            ntt_start = hold || (r == pulse_r);
            param_n   = (r == pulse_r) ? 17'd1024 : 17'($urandom_range(0, 131071));
        end
        check_output({tag, "_done_cycle"}, 0, 128'(done_r), 128'(last));
        check_output({tag, "_reads"}, 0, 128'(reads), 128'(exp_reads));
        check_output({tag, "_writes"}, 0, 128'(writes), 128'(exp_reads));
        check_output({tag, "_busy_cycles"}, 0, 128'(busy_cnt), 128'(last));
    endtask

    task automatic check_n8_table(input string tag);
        logic [49:0] got, want;
        check_output({tag, "_len"}, 0, 128'(rd_log.size()), 128'd12);
        for (int i = 0; i < 12; i++) begin
            got  = (i < rd_log.size()) ? rd_log[i] : '1;
            want = {17'(t_a1[i]), 17'(t_a2[i]), 16'(t_tw[i])};
            check_output(tag, i, 128'(got), 128'(want));
        end
    endtask

    initial begin
        int n;
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        ntt_start = 1'b0;
        param_n   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset", 0, 128'(obs), 128'd0);
        rst_n = 1'b1;
        idle_cycles("idle_after_reset", 2);

        $display("[TB] N=8 reference schedule");
        rd_log.delete();
        apply_stimulus("n8", 8, 1'b0, 0, 0);
        check_n8_table("n8_table");
        idle_cycles("idle1", 2);

        $display("[TB] N=8 with mid-run start pulse");
        apply_stimulus("n8_pulse", 8, 1'b0, 6, 0);
        idle_cycles("idle2", 1);

        $display("[TB] N=256 full run");
        apply_stimulus("n256", 256, 1'b0, 0, 0);
        idle_cycles("idle3", 1);

        $display("[TB] illegal lengths");
        apply_stimulus("n96", 96, 1'b0, 0, 0);
        idle_cycles("idle4", 1);
        apply_stimulus("n2", 2, 1'b0, 0, 0);
        idle_cycles("idle5", 1);
        apply_stimulus("n0", 0, 1'b0, 0, 0);
        idle_cycles("idle6", 1);

        $display("[TB] reset during stage 2 of N=16");
        apply_stimulus("n16_abort", 16, 1'b0, 0, 27);
        idle_cycles("idle_post_abort", 2);
        rd_log.delete();
        apply_stimulus("n8_after_abort", 8, 1'b0, 0, 0);
        check_n8_table("n8_table_after_abort");
        idle_cycles("idle7", 1);

        $display("[TB] start held high across completion");
        apply_stimulus("hold_n4", 4, 1'b1, 0, 0);
        param_n = 17'd8;
        idle_cycles("hold_gap", 1);
        apply_stimulus("hold_n8", 8, 1'b0, 0, 0);
        idle_cycles("idle8", 1);

        $display("[TB] randomized legal runs");
        for (int i = 0; i < 4; i++) begin
            n = 4 << $urandom_range(0, 4);
            apply_stimulus("rand_legal", n, 1'b0, int'($urandom_range(1, 10)), 0);
            idle_cycles("rand_gap", 1 + int'($urandom_range(0, 3)));
        end

        $display("[TB] randomized illegal runs");
        for (int i = 0; i < 3; i++) begin
            n = 2 * int'($urandom_range(2, 32000)) + 1;
            apply_stimulus("rand_illegal", n, 1'b0, 0, 0);
            idle_cycles("rand_gap_ill", 1 + int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
